tp_sequencer: RTL and testbench
===============================

// Module: tp_sequencer
// PURPOSE
//  Timing-pulse sequencer for the processor timing chain. Generates the
//  repeating TP1..TP4 strobe ring that feeds the m602 pulse-amplifier
//  channels and the major-state logic. Supports free-running (RUN),
//  single-cycle (STEP) and I/O-hold (PAUSE) operation.
//  The outputs are active-low strobes with the same shape as a pulse-amp
//  output, so downstream edge-triggered logic treats them as amp pulses.
// PARAMETERS
//  PULSE_W  9   low time of each TP strobe, in clk cycles (>=1)
//  TP_GAP   25  TPn start to TPn+1 start, in clk cycles (> PULSE_W)
// PORTS
//  clk        in   1  100 MHz system clock
//  rst_n      in   1  asynchronous, active-low reset
//  run        in   1  level; 1 = keep cycling, synchronous to clk
//  step       in   1  request one TP1..TP4 cycle; acted on at its rising edge
//  pause      in   1  level; 1 = hold before issuing the next TP strobe
//  tp_n       out  4  active-low strobes; tp_n[0]=TP1 .. tp_n[3]=TP4
//  phase      out  2  index of the current or most recent TP (0..3)
//  busy       out  1  1 while a TP cycle is in progress (any state but IDLE)
//  cycle_done out  1  1-cycle high pulse on the last cycle of the TP4 gap
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - tp_n=4'hF, phase=0, busy=0, cycle_done=0, state=IDLE.
//   - All counters clear and the registered step history clears.
//   - Reset asserted mid-pulse forces tp_n high immediately.
//  All outputs are registered. One down-counter, $clog2(TP_GAP+1) bits,
//   counts in both PULSE and GAP.
//  States: IDLE, PULSE, GAP, PAUSED.
//  IDLE:
//   - Start condition: run=1, or a step rising edge (step=1, step_q=0), sampled at edge k.
//   - On start: phase=0; tp_n[0] goes low from cycle k+1.
//  PULSE:
//   - tp_n[phase] is low for exactly PULSE_W cycles; every other bit stays high.
//   - Then enter GAP.
//  GAP:
//   - All tp_n high for TP_GAP-PULSE_W cycles.
//   - The last GAP cycle is the decision point.
//  Decision point, phase<3:
//   - pause=0: next cycle PULSE with phase+1.
//   - pause=1: enter PAUSED.
//  Decision point, phase==3:
//   - cycle_done=1 for that one cycle.
//   - If run=1: continue with pause handling as above, next phase=0.
//   - If run=0: return to IDLE (busy=0 the next cycle).
//  PAUSED:
//   - All tp_n high, phase held, busy=1.
//   - First edge with pause=0 (cycle P): PULSE of the next phase at P+1.
//  Timing for a start at cycle S (defaults):
//   - TPk is low on cycles S+25k .. S+25k+8.
//   - cycle_done is high on cycle S+99.
//   - Continuous RUN gives a 100-cycle (1 us) period.
//  Boundary rules:
//   - run dropping mid-cycle: the current TP1..TP4 cycle always completes; no truncation.
//   - step while busy: ignored, the edge is discarded. A held-high step gives one cycle only.
//   - step and run together in IDLE: a single start, treated as run.
//   - pause applies only at decision points. A pause pulse that starts and ends
//     within PULSE or GAP has no effect.
//   - At most one tp_n bit is low at any time; tp_n never glitches.
// TESTING
//  1. Reset: hold rst_n=0 with run=1 -> tp_n=F, busy=0, cycle_done=0.
//     Release rst_n -> TP1 goes low 1 cycle after the first run sample.
//  2. run=1 sampled at edge 0, defaults -> tp_n=E on cycles 1-9, D on 26-34,
//     B on 51-59, 7 on 76-84, F otherwise; cycle_done high on cycle 100;
//     TP1 low again at 101.
//  3. Single step: pulse step for 1 cycle with run=0 -> exactly one TP1..TP4
//     sequence, then busy=0. A second step pulse during TP2 -> ignored.
//  4. Pause: pause=1 across the TP2 decision point, released at cycle 200
//     -> tp_n stays F, busy=1, phase=1; TP3 low on cycles 201-209.
//  5. run deasserted during TP2 -> TP3 and TP4 still issue, cycle_done fires,
//     then IDLE with no further TP1.
//  6. Async reset pulsed mid-TP3 -> tp_n=F immediately, phase=0, and no
//     cycle_done pulse follows.

Source files
------------

// File: rtl/tp_sequencer_if.sv
// tp_sequencer_if
//  Groups the timing-pulse sequencer's control levels and strobe outputs.
//  master : the controller side that drives run/step/pause and watches the strobes
//  slave  : the sequencer itself
//  Signals:
//   run, step, pause   control inputs to the sequencer (synchronous to clk)
//   tp_n[3:0]          active-low TP1..TP4 strobes
//   phase[1:0]         index of the current or most recent TP
//   busy               sequencer is not idle
//   cycle_done         one-cycle pulse on the last cycle of the TP4 gap
interface tp_sequencer_if;
  logic       run;
  logic       step;
  logic       pause;
  logic [3:0] tp_n;
  logic [1:0] phase;
  logic       busy;
  logic       cycle_done;

  modport master (
    output run, step, pause,
    input  tp_n, phase, busy, cycle_done
  );

  modport slave (
    input  run, step, pause,
    output tp_n, phase, busy, cycle_done
  );
endinterface

// File: rtl/tp_sequencer.sv
// tp_sequencer
//  Timing-pulse sequencer: produces the repeating TP1..TP4 active-low strobe
//  ring with free-running (run), single-cycle (step) and hold (pause) modes.
//  Each TP occupies TP_GAP clocks: PULSE_W clocks low, then the rest high.
//  The last high clock of every TP slot is the decision point where pause,
//  run and the wrap from TP4 back to TP1 are evaluated.
//  Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    tp_sequencer_if.slave (run/step/pause in; tp_n/phase/busy/cycle_done out)
module tp_sequencer #(
  parameter int PULSE_W = 9,
  parameter int TP_GAP  = 25
) (
  input  logic          clk,
  input  logic          rst_n,
  tp_sequencer_if.slave bus
);

  localparam int CNT_W   = $clog2(TP_GAP + 1);
  localparam int GAP_LEN = TP_GAP - PULSE_W;

  localparam logic [CNT_W-1:0] ZERO       = CNT_W'(0);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    GAP    = 2'd2,
    PAUSED = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       phase_r;
  logic [3:0]       tp_n_r;
  logic             busy_r;
  logic             cycle_done_r;
  logic             step_q_r;

  logic             start_s;
  logic             last_phase_s;
  logic [1:0]       phase_inc_s;

  // Active-low strobe pattern with only the bit of the given phase low.
  function automatic logic [3:0] strobe_n(input logic [1:0] ph);
    strobe_n = ~(4'b0001 << ph);
  endfunction

  // Start request and phase helpers; 2-bit increment wraps TP4 back to TP1.
  always_comb begin
    start_s      = 1'b0;
    last_phase_s = (phase_r == 2'd3);
    phase_inc_s  = phase_r + 2'd1;
    if (bus.run || (bus.step && !step_q_r)) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
  end

  // Sequencer FSM with registered strobes, phase, busy and cycle_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= ZERO;
      phase_r      <= 2'd0;
      tp_n_r       <= 4'hF;
      busy_r       <= 1'b0;
      cycle_done_r <= 1'b0;
      step_q_r     <= 1'b0;
    end else begin
      // step history tracks every cycle so a step held or raised while busy
      // never produces a later start.
      step_q_r <= bus.step;
      case (state_r)
        IDLE: begin
          cycle_done_r <= 1'b0;
          if (start_s) begin
            state_r <= PULSE;
            phase_r <= 2'd0;
            tp_n_r  <= strobe_n(2'd0);
            cnt_r   <= PULSE_LOAD;
            busy_r  <= 1'b1;
          end else begin
            tp_n_r  <= 4'hF;
            busy_r  <= 1'b0;
          end
        end
        PULSE: begin
          if (cnt_r == ZERO) begin
            state_r      <= GAP;
            tp_n_r       <= 4'hF;
            cnt_r        <= GAP_LOAD;
            // A one-clock gap makes its first clock the decision point.
            cycle_done_r <= (GAP_LOAD == ZERO) && last_phase_s;
          end else begin
            cnt_r        <= cnt_r - ONE;
            cycle_done_r <= 1'b0;
          end
        end
        GAP: begin
          if (cnt_r == ZERO) begin
            cycle_done_r <= 1'b0;
            if (last_phase_s && !bus.run) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end else if (bus.pause) begin
              state_r <= PAUSED;
            end else begin
              state_r <= PULSE;
              phase_r <= phase_inc_s;
              tp_n_r  <= strobe_n(phase_inc_s);
              cnt_r   <= PULSE_LOAD;
            end
          end else begin
            cnt_r        <= cnt_r - ONE;
            // Raise cycle_done so it is high exactly on the TP4 decision clock.
            cycle_done_r <= (cnt_r == ONE) && last_phase_s;
          end
        end
        PAUSED: begin
          cycle_done_r <= 1'b0;
          if (!bus.pause) begin
            state_r <= PULSE;
            phase_r <= phase_inc_s;
            tp_n_r  <= strobe_n(phase_inc_s);
            cnt_r   <= PULSE_LOAD;
          end else begin
            tp_n_r  <= 4'hF;
          end
        end
        default: begin
          state_r      <= IDLE;
          cnt_r        <= ZERO;
          tp_n_r       <= 4'hF;
          busy_r       <= 1'b0;
          cycle_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tp_n       = tp_n_r;
  assign bus.phase      = phase_r;
  assign bus.busy       = busy_r;
  assign bus.cycle_done = cycle_done_r;

endmodule

// File: tb/tb_tp_sequencer.sv
// tb_tp_sequencer
//  Directed and randomized stimulus for tp_sequencer, checked every cycle
//  against a slot/offset reference model plus absolute timing expectations.
module tb_tp_sequencer;
  localparam int PULSE_W = 9;
  localparam int TP_GAP  = 25;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tp_sequencer_if bus();

  tp_sequencer #(.PULSE_W(PULSE_W), .TP_GAP(TP_GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: sequencer active?, held?, which TP slot, clock offset in slot.
  bit m_active, m_paused, m_stepq;
  int m_phase, m_off;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_paused = 1'b0; m_stepq = 1'b0;
    m_phase = 0; m_off = 0;
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (!m_active) begin
        if (bus.run || (bus.step && !m_stepq)) begin
          m_active = 1'b1; m_paused = 1'b0; m_phase = 0; m_off = 0;
        end
      end else if (m_paused) begin
        if (!bus.pause) begin
          m_paused = 1'b0; m_phase = (m_phase + 1) % 4; m_off = 0;
        end
      end else if (m_off == TP_GAP - 1) begin
        if (m_phase == 3 && !bus.run) m_active = 1'b0;
        else if (bus.pause) m_paused = 1'b1;
        else begin m_phase = (m_phase + 1) % 4; m_off = 0; end
      end else begin
        m_off++;
      end
      m_stepq = bus.step;
    end
  endtask

  function automatic logic [3:0] exp_tp();
    logic [3:0] one;
    one = 4'b0001;
    if (m_active && !m_paused && m_off < PULSE_W) return ~(one << m_phase);
    return 4'hF;
  endfunction

  // Advance one clock and compare all outputs against the model.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("tp_n", 32'(bus.tp_n), 32'(exp_tp()));
    chk("phase", 32'(bus.phase), 32'(m_phase));
    chk("busy", 32'(bus.busy), 32'(m_active));
    chk("cycle_done", 32'(bus.cycle_done),
        32'(m_active && !m_paused && m_phase == 3 && m_off == TP_GAP - 1));
    chk("one_low", 32'($countones(~bus.tp_n) <= 1), 32'd1);
  endtask

  // Absolute strobe pattern for a start with first TP1 clock at cycle 1 and
  // run dropped during the second period.
  function automatic logic [3:0] tbl_tp(input int c);
    logic [3:0] one;
    int k, o;
    one = 4'b0001;
    if (c < 1 || c > 200) return 4'hF;
    o = (c - 1) % TP_GAP;
    k = ((c - 1) / TP_GAP) % 4;
    if (o < PULSE_W) return ~(one << k);
    return 4'hF;
  endfunction

  int tp1_falls;
  logic prev_tp0;

  initial begin
    model_reset();
    bus.run = 1'b1; bus.step = 1'b0; bus.pause = 1'b0;

    // 1. Reset held with run=1.
    repeat (3) tick();
    chk("rst_tp_n", 32'(bus.tp_n), 32'hF);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.cycle_done), 32'd0);
    rst_n = 1'b1;

    // 2. Free run from edge 0; run dropped during TP2 of the second period (5.)
    for (int c = 1; c <= 230; c++) begin
      tick();
      chk("abs_tp_n", 32'(bus.tp_n), 32'(tbl_tp(c)));
      chk("abs_done", 32'(bus.cycle_done), 32'(c == 100 || c == 200));
      chk("abs_busy", 32'(bus.busy), 32'(c <= 200));
      if (c == 130) bus.run = 1'b0;
    end

    // 3. Single step, with a second step pulse during TP2 ignored.
    bus.step = 1'b1;
    tp1_falls = 0; prev_tp0 = bus.tp_n[0];
    for (int c = 1; c <= 130; c++) begin
      tick();
      if (prev_tp0 && !bus.tp_n[0]) tp1_falls++;
      prev_tp0 = bus.tp_n[0];
      bus.step = (c == 28);
    end
    chk("step_tp1_count", 32'(tp1_falls), 32'd1);
    chk("step_idle", 32'(bus.busy), 32'd0);

    // Held-high step gives one sequence only.
    bus.step = 1'b1;
    tp1_falls = 0; prev_tp0 = bus.tp_n[0];
    repeat (250) begin
      tick();
      if (prev_tp0 && !bus.tp_n[0]) tp1_falls++;
      prev_tp0 = bus.tp_n[0];
    end
    chk("held_step_count", 32'(tp1_falls), 32'd1);
    bus.step = 1'b0;
    tick();

    // 4. Pause across the TP2 decision point, released at cycle 200.
    bus.step = 1'b1;
    for (int c = 1; c <= 260; c++) begin
      tick();
      bus.step = 1'b0;
      if (c > 50 && c <= 200) begin
        chk("pause_tp_n", 32'(bus.tp_n), 32'hF);
        chk("pause_phase", 32'(bus.phase), 32'd1);
        chk("pause_busy", 32'(bus.busy), 32'd1);
      end else if (c >= 201 && c <= 209) begin
        chk("pause_tp3", 32'(bus.tp_n), 32'hB);
      end
      if (c == 40) bus.pause = 1'b1;
      if (c == 200) bus.pause = 1'b0;
    end

    // 6. Asynchronous reset in the middle of TP3.
    bus.step = 1'b1;
    for (int c = 1; c <= 55; c++) begin
      tick();
      bus.step = 1'b0;
    end
    chk("pre_rst_tp3", 32'(bus.tp_n), 32'hB);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_tp_n", 32'(bus.tp_n), 32'hF);
    chk("async_phase", 32'(bus.phase), 32'd0);
    chk("async_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (120) tick();

    // Randomized run/step/pause activity against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) bus.run = ~bus.run;
      if ($urandom_range(0, 29) == 0) bus.pause = ~bus.pause;
      bus.step = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
